// File: rtl/aq_gemac_pkg.sv
// Shared definitions for the GEMAC TX frame packer.
//  - tx_state_e     : packer FSM state encoding
//  - ETH_MIN_BYTES  : minimum Ethernet frame length without FCS
//  - hdr_word(len)  : length header word {len, 16'h0000}
//  - words(len)     : number of 32-bit words that hold len bytes
package aq_gemac_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StFill    = 3'd1,
    StWaitRdy = 3'd2,
    StHead    = 3'd3,
    StData    = 3'd4,
    StDiscard = 3'd5
  } tx_state_e;

  localparam logic [15:0] ETH_MIN_BYTES = 16'd60;

  function automatic logic [31:0] hdr_word(input logic [15:0] len);
    return {len, 16'h0000};
  endfunction

  function automatic logic [15:0] words(input logic [15:0] len);
    logic [16:0] sum;
    sum = {1'b0, len} + 17'd3;
    return {1'b0, sum[16:2]};
  endfunction

endpackage

// File: rtl/aq_gemac_tx_pack_ram.sv
// Simple dual-port frame RAM, 32 bits x DEPTH_WORDS.
// Byte-lane write enables on the write port, 1-cycle registered read on the read port.
// Ports:
//  clk    in   clock
//  we     in   per-byte write enables (bit i writes wdata[8*i+:8])
//  waddr  in   write word address
//  wdata  in   write data
//  raddr  in   read word address
//  rdata  out  registered read data (mem[raddr] of the previous cycle)
module aq_gemac_tx_pack_ram #(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned ADDR_W      = 9
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [31:0]       wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [31:0]       rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) begin
        mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/aq_gemac_tx_packer.sv
// Frame packer in front of the MAC TX buffer write port.
// Collects one frame from a byte stream into a word RAM, then writes a length header word
// followed by little-endian packed data words with start/end strobes.
// Optional feature macro: AQ_GEMAC_TX_PACKER_PAD_EN (pad frames shorter than 60 bytes with
// zero words; header carries the padded length).
// Ports:
//  clk, rst                  clock, synchronous active-high reset
//  in_valid/in_ready         byte handshake; in_data byte, in_last marks final byte
//  tx_buff_we                word write strobe to the MAC TX buffer
//  tx_buff_start/tx_buff_end strobes with the header word / last data word
//  tx_buff_data              header or data word
//  tx_buff_ready             MAC can accept a new frame
//  tx_buff_full              MAC buffer full, no write while high
//  busy                      FSM not idle
//  frame_done                pulse with the end word
//  drop                      pulse when an oversize frame is discarded
module aq_gemac_tx_packer
  import aq_gemac_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 512,
  parameter int unsigned MAX_BYTES   = 1514
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        tx_buff_we,
  output logic        tx_buff_start,
  output logic        tx_buff_end,
  output logic [31:0] tx_buff_data,
  input  logic        tx_buff_ready,
  input  logic        tx_buff_full,
  output logic        busy,
  output logic        frame_done,
  output logic        drop
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  tx_state_e   state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] len_q, len_d;
  logic [15:0] widx_q, widx_d;

  logic          accept;
  logic [15:0]   cnt_inc;
  logic          over;
  logic [15:0]   len_eff;
  logic [15:0]   n_words;
  logic          last_word;
  logic [31:0]   data_word;
  logic [15:0]   rd_idx;
  logic          ram_wr;
  logic [3:0]    lane_be;
  logic [3:0]    ram_we;
  logic [31:0]   ram_wdata;
  logic [AW-1:0] ram_waddr;
  logic [AW-1:0] ram_raddr;
  logic [31:0]   ram_rdata;

  assign accept  = in_valid & in_ready;
  assign cnt_inc = cnt_q + 16'd1;
  assign over    = {16'd0, cnt_inc} > MAX_BYTES;

  // Lane 0 writes the whole word so the unused upper bytes of a final partial word read as 0.
  assign lane_be   = (cnt_q[1:0] == 2'd0) ? 4'hF : (4'b0001 << cnt_q[1:0]);
  assign ram_wdata = {24'h0, in_data} << {cnt_q[1:0], 3'b000};
  assign ram_we    = ram_wr ? lane_be : 4'h0;
  assign ram_waddr = AW'(cnt_q >> 2);
  assign ram_raddr = AW'(rd_idx);

`ifdef AQ_GEMAC_TX_PACKER_PAD_EN
  assign len_eff   = (len_q < ETH_MIN_BYTES) ? ETH_MIN_BYTES : len_q;
  // Pad words beyond the stored data are generated as zeros.
  assign data_word = (widx_q < words(len_q)) ? ram_rdata : 32'h0;
`else
  assign len_eff   = len_q;
  assign data_word = ram_rdata;
`endif

  assign n_words   = words(len_eff);
  assign last_word = (widx_q == n_words - 16'd1);
  assign busy      = (state_q != StIdle);

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    len_d         = len_q;
    widx_d        = widx_q;
    in_ready      = 1'b0;
    tx_buff_we    = 1'b0;
    tx_buff_start = 1'b0;
    tx_buff_end   = 1'b0;
    tx_buff_data  = 32'h0;
    frame_done    = 1'b0;
    drop          = 1'b0;
    ram_wr        = 1'b0;
    rd_idx        = widx_q;

    unique case (state_q)
      StIdle: begin
        cnt_d   = 16'd0;
        state_d = StFill;
      end

      StFill: begin
        in_ready = 1'b1;
        if (accept) begin
          if (over) begin
            cnt_d = 16'd0;
            // Overflow on the final byte itself: drop right away, nothing left to skip.
            if (in_last) begin
              drop = 1'b1;
            end else begin
              state_d = StDiscard;
            end
          end else begin
            ram_wr = 1'b1;
            cnt_d  = cnt_inc;
            if (in_last) begin
              len_d   = cnt_inc;
              state_d = StWaitRdy;
            end
          end
        end
      end

      StDiscard: begin
        in_ready = 1'b1;
        if (accept && in_last) begin
          drop    = 1'b1;
          state_d = StFill;
        end
      end

      StWaitRdy: begin
        if (tx_buff_ready) begin
          state_d = StHead;
        end
      end

      StHead: begin
        // Prefetch word 0 so it is on the RAM output when DATA starts.
        rd_idx       = 16'd0;
        tx_buff_data = hdr_word(len_eff);
        if (!tx_buff_full) begin
          tx_buff_we    = 1'b1;
          tx_buff_start = 1'b1;
          widx_d        = 16'd0;
          state_d       = StData;
        end
      end

      StData: begin
        tx_buff_data = data_word;
        // While stalled, re-read the current word so it stays on the RAM output.
        if (!tx_buff_full) begin
          tx_buff_we = 1'b1;
          rd_idx     = widx_q + 16'd1;
          if (last_word) begin
            tx_buff_end = 1'b1;
            frame_done  = 1'b1;
            cnt_d       = 16'd0;
            state_d     = StFill;
          end else begin
            widx_d = widx_q + 16'd1;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
      len_q   <= 16'd0;
      widx_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      widx_q  <= widx_d;
    end
  end

  aq_gemac_tx_pack_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

endmodule
